// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: four-digit seven-segment scan scheduler with blanking and frame-synchronous double buffering
module seg7_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        lz_blank,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_done,
  output logic [3:0]  am,
  output logic [7:0]  out
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   sh_value, pend_value;
  logic [3:0]    sh_dp, pend_dp;
  logic          pending;
  logic          wrap, frame, commit, blank, dark;
  logic [3:0]    nib, lzb;
  logic [6:0]    seg;
  assign wrap   = cnt == CW'(SCAN_DIV - 1);
  assign frame  = wrap && idx == 2'd3;
  assign commit = frame && (pending || load);
  assign blank  = cnt < CW'(BLANK_CYCLES);
  assign nib    = sh_value[{idx, 2'b00} +: 4];
  assign lzb    = {sh_value[15:12] == 4'd0,
                   sh_value[15:8]  == 8'd0,
                   sh_value[15:4]  == 12'd0,
                   1'b0};
  assign dark   = !digit_en[idx] || (lz_blank && lzb[idx]);
  // BCD nibble to active-low {a..g}; non-decimal nibbles render as a dash
  always_comb begin
    seg = 7'b1111110;
    case (nib)
      4'd0: seg = 7'b0000001;
      4'd1: seg = 7'b1001111;
      4'd2: seg = 7'b0010010;
      4'd3: seg = 7'b0000110;
      4'd4: seg = 7'b1001100;
      4'd5: seg = 7'b0100100;
      4'd6: seg = 7'b1100000;
      4'd7: seg = 7'b0001101;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0000100;
      default: seg = 7'b1111110;
    endcase
  end
  // slot prescaler and digit index
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      idx <= wrap ? idx + 2'd1 : idx;
    end
  end
  // load handshake: latest request waits in pend, moves to shadow only at a frame boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= 1'b0;
      pend_value <= '0;
      pend_dp    <= '0;
      sh_value   <= '0;
      sh_dp      <= '0;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pending    <= !frame && (pending || load);
      pend_value <= load ? value : pend_value;
      pend_dp    <= load ? dp_in : pend_dp;
      sh_value   <= commit ? (load ? value : pend_value) : sh_value;
      sh_dp      <= commit ? (load ? dp_in : pend_dp) : sh_dp;
      load_ack   <= commit;
      frame_done <= frame;
    end
  end
  // registered anode/segment drive; blanking interval and dark digits force everything off
  always_ff @(posedge clk) begin
    if (reset) begin
      am  <= 4'b1111;
      out <= 8'hFF;
    end else begin
      am  <= (blank || dark) ? 4'b1111 : ~(4'b0001 << idx);
      out <= (blank || dark) ? 8'hFF : {seg, ~sh_dp[idx]};
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed scoreboard bench for the scan scheduler
module tb_seg7_scan_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = 4'hF;
  logic        lz_blank = 1'b0;
  logic        load = 1'b0;
  logic        load_ack, frame_done;
  logic [3:0]  am;
  logic [7:0]  out;
  int total = 0;
  int bad = 0;
  logic [11:0] q[$];

  seg7_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .digit_en(digit_en),
    .lz_blank(lz_blank), .load(load), .load_ack(load_ack), .frame_done(frame_done),
    .am(am), .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    value = v;
    dp_in = dp;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int exp_cycles, input logic exp_ack);
    int n = 0;
    int acks = 0;
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      n++;
      acks += int'(load_ack);
      seen = frame_done;
    end
    chk({tag, "_frame_seen"}, 32'(seen), 32'd1);
    if (exp_cycles > 0) chk({tag, "_frame_latency"}, 32'(n), 32'(exp_cycles));
    chk({tag, "_ack_count"}, 32'(acks), 32'(exp_ack));
    chk({tag, "_ack_at_boundary"}, 32'(load_ack), 32'(exp_ack));
  endtask

  task automatic check_frame(input string tag, input logic [15:0] am_p, input logic [31:0] out_p);
    logic [11:0] e;
    int acks = 0;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 8; c++)
        q.push_back(c < 2 ? 12'hFFF : {am_p[s*4 +: 4], out_p[s*8 +: 8]});
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        acks += int'(load_ack);
        e = q.pop_front();
        chk($sformatf("%s_s%0d_c%0d", tag, s, c), {20'd0, am, out}, {20'd0, e});
      end
    chk({tag, "_no_extra_ack"}, 32'(acks), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_am", 32'(am), 32'hF);
    chk("rst_out", 32'(out), 32'hFF);
    chk("rst_ack", 32'(load_ack), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    reset = 1'b0;
    wait_frame("t1", 32, 1'b0);
    do_load(16'h1234, 4'h0);
    wait_frame("t2", 0, 1'b1);
    check_frame("t2", 16'h7BDE, 32'h9F250D99);
    lz_blank = 1'b1;
    do_load(16'h0070, 4'h0);
    wait_frame("t3", 0, 1'b1);
    check_frame("t3", 16'hFFDE, 32'hFFFF1B03);
    lz_blank = 1'b0;
    digit_en = 4'b1011;
    do_load(16'h0A05, 4'b0001);
    wait_frame("t4", 0, 1'b1);
    check_frame("t4", 16'h7FDE, 32'h03FF0348);
    digit_en = 4'hF;
    do_load(16'h1111, 4'h0);
    repeat (4) @(negedge clk);
    do_load(16'h2222, 4'h0);
    wait_frame("t5", 0, 1'b1);
    check_frame("t5", 16'h7BDE, 32'h25252525);
    do_load(16'h9999, 4'hF);
    repeat (18) @(negedge clk);
    chk("t6_pre_reset_am", 32'(am), 32'hB);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_am", 32'(am), 32'hF);
    chk("t6_rst_out", 32'(out), 32'hFF);
    chk("t6_rst_ack", 32'(load_ack), 32'd0);
    reset = 1'b0;
    wait_frame("t6", 32, 1'b0);
    check_frame("t6", 16'h7BDE, 32'h03030303);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
